gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
Shares one seq_gcd engine between two requesters inside user_proj: port 0 is driven from Logic Analyzer probes and port 1 from the Wishbone slave. The block runs round-robin arbitration, latches the winner's operands and issues them to the engine. It then routes the engine's result back to the requester that was granted. Only one transaction is in flight at a time; the block owns the engine's request and response handshakes.

Parameters:
W, 32, operand and result width in bits.

Ports:
wb_clk_i  input  1  clock.
wb_rst_i  input  1  reset; synchronous, active-high.
p0_req_val  input  1  port 0 request valid.
p0_req_rdy  output  1  port 0 request accepted when high together with p0_req_val.
p0_req_a  input  W  port 0 operand A.
p0_req_b  input  W  port 0 operand B.
p0_resp_val  output  1  port 0 result valid.
p0_resp_rdy  input  1  port 0 result consumed.
p0_resp_result  output  W  port 0 result.
p1_req_val, p1_req_rdy, p1_req_a, p1_req_b, p1_resp_val, p1_resp_rdy, p1_resp_result  same directions and widths as port 0, for port 1.
eng_req_val  output  1  request valid to the engine.
eng_req_rdy  input  1  engine can accept a request.
eng_req_a  output  W  operand A to the engine.
eng_req_b  output  W  operand B to the engine.
eng_resp_val  input  1  engine result valid.
eng_resp_rdy  output  1  arbiter can accept the engine result.
eng_resp_result  input  W  engine result.
busy  output  1  high in every state except IDLE.
grant_id  output  1  port currently granted; holds its value while in IDLE.

Behaviour:
- All handshakes are valid/ready; a transfer occurs on a rising clock edge where both valid and ready are high.
- States and transitions:
  - IDLE -> ISSUE on an accepted request.
  - ISSUE -> WAIT on eng_req_val & eng_req_rdy.
  - WAIT -> RESP on eng_resp_val & eng_resp_rdy.
  - RESP -> IDLE on the granted port's resp_val & resp_rdy.
- Arbitration in IDLE:
  - The winner is computed combinationally from p0_req_val, p1_req_val and the last_grant register.
  - If only one port is valid, that port wins.
  - If both are valid, the port != last_grant wins.
  - Only the winner sees req_rdy=1. All req_rdy outputs are 0 outside IDLE.
- On an accepted request:
  - The operands are latched into a_q/b_q.
  - grant_id takes the winner's index.
  - last_grant is updated to the winner's index in the same cycle.
- ISSUE:
  - eng_req_val=1 with eng_req_a=a_q and eng_req_b=b_q.
  - These values are held stable until the engine accepts.
- WAIT:
  - eng_resp_rdy=1; it is 0 in every other state.
  - On transfer, eng_resp_result is latched into res_q.
- RESP:
  - The granted port's resp_val=1 with resp_result=res_q.
  - The other port's resp_val=0.
  - Values are held until resp_rdy is seen.
  - Both resp_result outputs always show res_q; only resp_val qualifies them.
- Latency:
  - Request accepted at cycle T -> eng_req_val high at T+1.
  - Engine result accepted at cycle R -> port resp_val high at R+1.
  - Minimum time from accept back to IDLE: 4 cycles plus the engine's own latency.
- Reset values:
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - grant_id=0, a_q/b_q/res_q=0.
  - Every valid and ready output is 0 except arbitration-driven req_rdy.
  - busy=0.
- Boundary conditions:
  - A request that arrives while busy is stalled with req_rdy=0. It is never dropped.
  - eng_resp_val outside WAIT is not accepted (eng_resp_rdy=0).
  - resp_rdy asserted by the non-granted port is ignored.
  - Reset mid-operation forces IDLE in the next cycle and discards the transaction. The engine must share wb_rst_i.
  - A requester that drops req_val in IDLE before acceptance is not granted.
  - Operand values of 0 are passed through unchanged; the engine defines the result.

Optional Feature:
GCD_ARB_PERF_EN.
- When defined, the following are added:
  - 16-bit outputs p0_done_cnt and p1_done_cnt. Each increments on that port's completed response handshake and wraps from 0xFFFF to 0.
  - A 16-bit output stall_cnt. It increments every cycle in which a non-granted port has req_val=1 while busy, saturating at 0xFFFF.
  - An input perf_clr that zeroes all three counters synchronously. perf_clr has priority over an increment in the same cycle.
  - All three counters reset to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Port 0 request a=10312050, b=29460792 with an ideal engine -> p0_resp_result=138 and p1_resp_val stays 0. eng_req_val rises one cycle after p0 acceptance.
- Both ports valid in the cycle after reset (p0 a=1993627629, b=1177417612; p1 a=2097015289, b=3812041926) -> p0 is served first with result 7, then p1 with result 1. grant_id goes 0 then 1.
- Both ports continuously valid for 4 transactions -> grants alternate 0,1,0,1.
- Port 1 request a=1924134885, b=3151131255; hold p1_resp_rdy=0 for 10 cycles -> p1_resp_val and result 135 are held stable, no new request is accepted during the hold, and the block returns to IDLE on release.
- Assert wb_rst_i during WAIT -> next cycle busy=0, all resp_val=0, eng_resp_rdy=0. A new p0 request a=992211318, b=512609597 then returns result 1.
- With GCD_ARB_PERF_EN: 3 p0 and 2 p1 completions -> p0_done_cnt=3 and p1_done_cnt=2. Pulsing perf_clr returns all counters to 0.

Source files
------------

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one seq_gcd engine between two requesters.
// Port 0 is fed from the Logic Analyzer probes and port 1 from the Wishbone slave.
// Round-robin arbitration picks a winner in IDLE and latches its operands.
// The operands are issued to the engine, and the engine result is routed back to the granted port.
// Only one transaction is in flight at a time.
//
// Handshakes: every *_val/*_rdy pair transfers on a rising edge where both are high.
// A valid, once raised by this block, holds itself and its payload stable until that transfer.
//
// Optional build macro GCD_ARB_PERF_EN adds these performance counters:
//   p0_done_cnt, p1_done_cnt, stall_cnt (outputs) and perf_clr (input).
module gcd_arbiter #(
  parameter int W = 32
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
`ifdef GCD_ARB_PERF_EN
  input  logic         perf_clr,
  output logic [15:0]  p0_done_cnt,
  output logic [15:0]  p1_done_cnt,
  output logic [15:0]  stall_cnt,
`endif
  input  logic         p0_req_val,
  output logic         p0_req_rdy,
  input  logic [W-1:0] p0_req_a,
  input  logic [W-1:0] p0_req_b,
  output logic         p0_resp_val,
  input  logic         p0_resp_rdy,
  output logic [W-1:0] p0_resp_result,
  input  logic         p1_req_val,
  output logic         p1_req_rdy,
  input  logic [W-1:0] p1_req_a,
  input  logic [W-1:0] p1_req_b,
  output logic         p1_resp_val,
  input  logic         p1_resp_rdy,
  output logic [W-1:0] p1_resp_result,
  output logic         eng_req_val,
  input  logic         eng_req_rdy,
  output logic [W-1:0] eng_req_a,
  output logic [W-1:0] eng_req_b,
  input  logic         eng_resp_val,
  output logic         eng_resp_rdy,
  input  logic [W-1:0] eng_resp_result,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t       r_state;
  logic         r_last_grant;
  logic         r_grant_id;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res;

  logic         w_idle;
  logic         w_any_req;
  logic         w_winner;
  logic         w_accept;
  logic [W-1:0] w_win_a;
  logic [W-1:0] w_win_b;
  logic         w_resp_done;

  // The arbitration result is only meaningful in IDLE.
  // On a tie, the port that was not granted last time wins.
  assign w_idle    = (r_state == S_IDLE);
  assign w_any_req = p0_req_val | p1_req_val;
  assign w_winner  = (p0_req_val & p1_req_val) ? ~r_last_grant : p1_req_val;
  assign w_accept  = w_idle & w_any_req;
  assign w_win_a   = w_winner ? p1_req_a : p0_req_a;
  assign w_win_b   = w_winner ? p1_req_b : p0_req_b;

  // Only the winning port sees ready, and only while a request is pending in IDLE.
  assign p0_req_rdy = w_accept & ~w_winner;
  assign p1_req_rdy = w_accept &  w_winner;

  // Engine-side handshakes are decoded straight from the state register.
  assign eng_req_val  = (r_state == S_ISSUE);
  assign eng_req_a    = r_a;
  assign eng_req_b    = r_b;
  assign eng_resp_rdy = (r_state == S_WAIT);

  // Both result buses always show the latched result; resp_val qualifies them.
  assign p0_resp_val    = (r_state == S_RESP) & ~r_grant_id;
  assign p1_resp_val    = (r_state == S_RESP) &  r_grant_id;
  assign p0_resp_result = r_res;
  assign p1_resp_result = r_res;

  // The ready of the non-granted port is deliberately ignored.
  assign w_resp_done = r_grant_id ? p1_resp_rdy : p0_resp_rdy;

  assign busy     = ~w_idle;
  assign grant_id = r_grant_id;

  // Transaction FSM, operand and result latches, grant bookkeeping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_win_a;
            r_b          <= w_win_b;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_req_rdy) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_resp_val) begin
            r_res   <= eng_resp_result;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GCD_ARB_PERF_EN
  logic [15:0] r_p0_done_cnt;
  logic [15:0] r_p1_done_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_p0_done;
  logic        w_p1_done;
  logic        w_stall;

  assign w_p0_done = p0_resp_val & p0_resp_rdy;
  assign w_p1_done = p1_resp_val & p1_resp_rdy;
  assign w_stall   = ~w_idle & (r_grant_id ? p0_req_val : p1_req_val);

  // Completion counters wrap; the stall counter saturates; clear beats increment.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || perf_clr) begin
      r_p0_done_cnt <= '0;
      r_p1_done_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_p0_done) r_p0_done_cnt <= r_p0_done_cnt + 16'd1;
      if (w_p1_done) r_p1_done_cnt <= r_p1_done_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign p0_done_cnt = r_p0_done_cnt;
  assign p1_done_cnt = r_p1_done_cnt;
  assign stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: self-checking bench for gcd_arbiter with a behavioural GCD engine.
// Define GCD_ARB_PERF_EN to also exercise the performance counters.
module tb_gcd_arbiter;
  localparam int W = 32;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i;
`ifdef GCD_ARB_PERF_EN
  logic         perf_clr;
  logic [15:0]  p0_done_cnt, p1_done_cnt, stall_cnt;
`endif
  logic         p0_req_val, p0_req_rdy, p0_resp_val, p0_resp_rdy;
  logic [W-1:0] p0_req_a, p0_req_b, p0_resp_result;
  logic         p1_req_val, p1_req_rdy, p1_resp_val, p1_resp_rdy;
  logic [W-1:0] p1_req_a, p1_req_b, p1_resp_result;
  logic         eng_req_val, eng_req_rdy, eng_resp_val, eng_resp_rdy;
  logic [W-1:0] eng_req_a, eng_req_b, eng_resp_result;
  logic         busy, grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  // engine model state
  int           eng_lat = 0;
  logic         eng_busy;
  int           eng_cnt;
  logic         eng_val_m;
  logic [W-1:0] eng_res_m;
  logic         spurious = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  gcd_arbiter #(.W(W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
`ifdef GCD_ARB_PERF_EN
    .perf_clr(perf_clr), .p0_done_cnt(p0_done_cnt), .p1_done_cnt(p1_done_cnt),
    .stall_cnt(stall_cnt),
`endif
    .p0_req_val(p0_req_val), .p0_req_rdy(p0_req_rdy), .p0_req_a(p0_req_a),
    .p0_req_b(p0_req_b), .p0_resp_val(p0_resp_val), .p0_resp_rdy(p0_resp_rdy),
    .p0_resp_result(p0_resp_result),
    .p1_req_val(p1_req_val), .p1_req_rdy(p1_req_rdy), .p1_req_a(p1_req_a),
    .p1_req_b(p1_req_b), .p1_resp_val(p1_resp_val), .p1_resp_rdy(p1_resp_rdy),
    .p1_resp_result(p1_resp_result),
    .eng_req_val(eng_req_val), .eng_req_rdy(eng_req_rdy), .eng_req_a(eng_req_a),
    .eng_req_b(eng_req_b), .eng_resp_val(eng_resp_val), .eng_resp_rdy(eng_resp_rdy),
    .eng_resp_result(eng_resp_result),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // ---------------- behavioural engine (shares reset) ----------------
  assign eng_req_rdy     = ~eng_busy;
  assign eng_resp_val    = eng_val_m | spurious;
  assign eng_resp_result = spurious ? 32'hDEAD_BEEF : eng_res_m;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      eng_busy  <= 1'b0;
      eng_val_m <= 1'b0;
      eng_cnt   <= 0;
      eng_res_m <= '0;
    end else if (eng_val_m) begin
      if (eng_resp_rdy) begin
        eng_val_m <= 1'b0;
        eng_busy  <= 1'b0;
      end
    end else if (eng_busy) begin
      if (eng_cnt == 0) eng_val_m <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end else if (eng_req_val) begin
      eng_busy  <= 1'b1;
      eng_res_m <= gcd_f(eng_req_a, eng_req_b);
      eng_cnt   <= eng_lat;
    end
  end

  // ---------------- scoreboard: pop on each response handshake ----------------
  always @(negedge wb_clk_i) begin
    logic [W-1:0] e;
    if (!wb_rst_i && p0_resp_val && p0_resp_rdy) begin
      n_tests++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_p0_unexpected got result=%0d with nothing expected", p0_resp_result);
      end else begin
        e = exp0_q.pop_front();
        if (p0_resp_result !== e) begin
          n_fail++;
          $display("FAIL sb_p0_result got=%0d exp=%0d", p0_resp_result, e);
        end
      end
    end
    if (!wb_rst_i && p1_resp_val && p1_resp_rdy) begin
      n_tests++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_p1_unexpected got result=%0d with nothing expected", p1_resp_result);
      end else begin
        e = exp1_q.pop_front();
        if (p1_resp_result !== e) begin
          n_fail++;
          $display("FAIL sb_p1_result got=%0d exp=%0d", p1_resp_result, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    wb_rst_i = 1'b1;
    p0_req_val = 1'b0; p1_req_val = 1'b0;
    p0_req_a = '0; p0_req_b = '0; p1_req_a = '0; p1_req_b = '0;
    p0_resp_rdy = 1'b1; p1_resp_rdy = 1'b1;
    spurious = 1'b0;
`ifdef GCD_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
  endtask

  // Raise a request, push its expected result once accepted; returns at accept edge + 1.
  task automatic send(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp);
    bit ok;
    ok = 1'b0;
    if (port == 1'b0) begin p0_req_a = a; p0_req_b = b; p0_req_val = 1'b1; end
    else begin p1_req_a = a; p1_req_b = b; p1_req_val = 1'b1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge wb_clk_i);
      if ((port == 1'b0 && p0_req_rdy) || (port == 1'b1 && p1_req_rdy)) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_accept port=%0d got req_rdy=0 for 200 cycles exp req_rdy=1", port);
    end else if (port == 1'b0) exp0_q.push_back(exp);
    else exp1_q.push_back(exp);
    @(posedge wb_clk_i);
    #1;
    if (port == 1'b0) p0_req_val = 1'b0;
    else p1_req_val = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge wb_clk_i);
      if (!busy) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle got busy=1 after %0d cycles exp busy=0", max_cyc);
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge wb_clk_i);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_tests++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0", grant_id); end
    n_tests++; if (eng_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_eng_req_val got=%b exp=0", eng_req_val); end
    n_tests++; if (eng_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_eng_resp_rdy got=%b exp=0", eng_resp_rdy); end
    n_tests++; if ({p0_resp_val, p1_resp_val} !== 2'b00) begin n_fail++; $display("FAIL rst_resp_val got=%b exp=00", {p0_resp_val, p1_resp_val}); end
    n_tests++; if ({p0_req_rdy, p1_req_rdy} !== 2'b00) begin n_fail++; $display("FAIL rst_req_rdy got=%b exp=00", {p0_req_rdy, p1_req_rdy}); end
    n_tests++; if (p0_resp_result !== 32'd0) begin n_fail++; $display("FAIL rst_result got=%0d exp=0", p0_resp_result); end
    n_tests++; if ({eng_req_a, eng_req_b} !== 64'd0) begin n_fail++; $display("FAIL rst_operands got=%0h exp=0", {eng_req_a, eng_req_b}); end
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_single();
    bit seen, p1_bad;
    seen = 1'b0; p1_bad = 1'b0;
    eng_lat = 0;
    send(1'b0, 32'd10312050, 32'd29460792, 32'd138);
    @(negedge wb_clk_i);  // one cycle after the accept edge
    n_tests++; if (eng_req_val !== 1'b1) begin n_fail++; $display("FAIL single_issue_lat got eng_req_val=%b exp=1", eng_req_val); end
    n_tests++; if (eng_req_a !== 32'd10312050) begin n_fail++; $display("FAIL single_eng_a got=%0d exp=10312050", eng_req_a); end
    n_tests++; if (eng_req_b !== 32'd29460792) begin n_fail++; $display("FAIL single_eng_b got=%0d exp=29460792", eng_req_b); end
    n_tests++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant got=%b exp=0", grant_id); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_tests++; if (eng_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL single_resp_rdy_issue got=%b exp=0", eng_resp_rdy); end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (p1_resp_val) p1_bad = 1'b1;
      if (eng_resp_val && eng_resp_rdy) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL single_eng_resp got no engine handshake exp one within 50 cycles"); end
    @(negedge wb_clk_i);  // one cycle after the engine result edge
    n_tests++; if (p0_resp_val !== 1'b1) begin n_fail++; $display("FAIL single_resp_lat got p0_resp_val=%b exp=1", p0_resp_val); end
    n_tests++; if (p0_resp_result !== 32'd138) begin n_fail++; $display("FAIL single_result got=%0d exp=138", p0_resp_result); end
    if (p1_resp_val) p1_bad = 1'b1;
    n_tests++; if (p1_bad !== 1'b0) begin n_fail++; $display("FAIL single_p1_quiet got p1_resp_val=1 exp=0"); end
    wait_idle(20);
    // zero operand passes through unchanged
    send(1'b1, 32'd0, 32'd1234, 32'd1234);
    @(negedge wb_clk_i);
    n_tests++; if ({eng_req_a, eng_req_b} !== {32'd0, 32'd1234}) begin n_fail++; $display("FAIL zero_operand got a=%0d b=%0d exp a=0 b=1234", eng_req_a, eng_req_b); end
    n_tests++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL zero_grant got=%b exp=1", grant_id); end
    wait_idle(20);
  endtask

  task automatic test_tie();
    int order[$];
    bit r0, r1;
    do_reset();
    eng_lat = $urandom_range(0, 3);
    p0_req_a = 32'd1993627629; p0_req_b = 32'd1177417612; p0_req_val = 1'b1;
    p1_req_a = 32'd2097015289; p1_req_b = 32'd3812041926; p1_req_val = 1'b1;
    for (int i = 0; i < 200 && order.size() < 2; i++) begin
      @(negedge wb_clk_i);
      r0 = p0_req_rdy; r1 = p1_req_rdy;
      n_tests++; if (r0 && r1) begin n_fail++; $display("FAIL tie_both_rdy got rdy=11 exp one-hot"); end
      if (r0) begin order.push_back(0); exp0_q.push_back(32'd7); end
      if (r1) begin order.push_back(1); exp1_q.push_back(32'd1); end
      @(posedge wb_clk_i);
      #1;
      if (r0 || r1) begin
        n_tests++; if (grant_id !== r1) begin n_fail++; $display("FAIL tie_grant_id got=%b exp=%b", grant_id, r1); end
      end
      if (r0) p0_req_val = 1'b0;
      if (r1) p1_req_val = 1'b0;
    end
    n_tests++;
    if (order.size() != 2) begin n_fail++; $display("FAIL tie_count got=%0d grants exp=2", order.size()); end
    else if (order[0] != 0 || order[1] != 1) begin n_fail++; $display("FAIL tie_order got=%0d,%0d exp=0,1", order[0], order[1]); end
    p0_req_val = 1'b0; p1_req_val = 1'b0;
    wait_idle(50);
  endtask

  task automatic test_alternate();
    int got;
    bit exp_next, port;
    got = 0;
    exp_next = 1'b0;  // the previous grant went to port 1
    eng_lat = $urandom_range(0, 2);
    p0_req_a = $urandom; p0_req_b = $urandom; p0_req_val = 1'b1;
    p1_req_a = $urandom; p1_req_b = $urandom; p1_req_val = 1'b1;
    for (int i = 0; i < 400 && got < 4; i++) begin
      @(negedge wb_clk_i);
      if (p0_req_rdy || p1_req_rdy) begin
        port = p1_req_rdy;
        n_tests++; if (port !== exp_next) begin n_fail++; $display("FAIL alt_grant_%0d got=%b exp=%b", got, port, exp_next); end
        if (port) exp1_q.push_back(gcd_f(p1_req_a, p1_req_b));
        else exp0_q.push_back(gcd_f(p0_req_a, p0_req_b));
        @(posedge wb_clk_i);
        #1;
        if (port) begin p1_req_a = $urandom; p1_req_b = $urandom; end
        else begin p0_req_a = $urandom; p0_req_b = $urandom; end
        exp_next = ~port;
        got++;
      end
    end
    p0_req_val = 1'b0; p1_req_val = 1'b0;
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL alt_count got=%0d exp=4", got); end
    wait_idle(50);
  endtask

  task automatic test_hold();
    bit seen;
    seen = 1'b0;
    eng_lat = 1;
    p1_resp_rdy = 1'b0;
    send(1'b1, 32'd1924134885, 32'd3151131255, 32'd135);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (p1_resp_val) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL hold_resp got p1_resp_val=0 for 50 cycles exp=1"); end
    @(posedge wb_clk_i);
    #1;
    // a stalled p0 request, plus a stray engine response, during the hold
    p0_req_a = 32'd5; p0_req_b = 32'd10; p0_req_val = 1'b1;
    p0_resp_rdy = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      n_tests++; if (p1_resp_val !== 1'b1) begin n_fail++; $display("FAIL hold_val_%0d got=%b exp=1", i, p1_resp_val); end
      n_tests++; if (p1_resp_result !== 32'd135) begin n_fail++; $display("FAIL hold_result_%0d got=%0d exp=135", i, p1_resp_result); end
      n_tests++; if (p0_req_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_p0_rdy_%0d got=%b exp=0", i, p0_req_rdy); end
      n_tests++; if (p0_resp_val !== 1'b0) begin n_fail++; $display("FAIL hold_p0_val_%0d got=%b exp=0", i, p0_resp_val); end
      n_tests++; if (eng_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_eng_rdy_%0d got=%b exp=0", i, eng_resp_rdy); end
    end
    // p0 withdraws before the block is free again: it must not be granted
    @(posedge wb_clk_i);
    #1;
    spurious = 1'b0;
    p0_req_val = 1'b0;
    p1_resp_rdy = 1'b1;
    @(posedge wb_clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_idle_%0d got busy=%b exp=0", i, busy); end
      n_tests++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL hold_grant_keep_%0d got=%b exp=1", i, grant_id); end
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    eng_lat = 6;
    send(1'b0, 32'd12, 32'd18, 32'd6);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (eng_resp_rdy) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL midrst_wait got eng_resp_rdy=0 exp WAIT within 20 cycles"); end
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_tests++; if ({p0_resp_val, p1_resp_val} !== 2'b00) begin n_fail++; $display("FAIL midrst_resp_val got=%b exp=00", {p0_resp_val, p1_resp_val}); end
    n_tests++; if (eng_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_eng_rdy got=%b exp=0", eng_resp_rdy); end
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    eng_lat = 2;
    send(1'b0, 32'd992211318, 32'd512609597, 32'd1);
    wait_idle(30);
    n_tests++; if (exp0_q.size() != 0) begin n_fail++; $display("FAIL midrst_drain got=%0d pending exp=0", exp0_q.size()); end
  endtask

`ifdef GCD_ARB_PERF_EN
  task automatic test_perf();
    logic [W-1:0] a, b;
    perf_clr = 1'b1;
    @(posedge wb_clk_i);
    #1 perf_clr = 1'b0;
    eng_lat = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      send((i >= 3), a, b, gcd_f(a, b));
      wait_idle(30);
    end
    @(negedge wb_clk_i);
    n_tests++; if (p0_done_cnt !== 16'd3) begin n_fail++; $display("FAIL perf_p0_done got=%0d exp=3", p0_done_cnt); end
    n_tests++; if (p1_done_cnt !== 16'd2) begin n_fail++; $display("FAIL perf_p1_done got=%0d exp=2", p1_done_cnt); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL perf_stall got=%0d exp=0", stall_cnt); end
    @(posedge wb_clk_i);
    #1 perf_clr = 1'b1;
    @(posedge wb_clk_i);
    #1 perf_clr = 1'b0;
    @(negedge wb_clk_i);
    n_tests++; if ({p0_done_cnt, p1_done_cnt, stall_cnt} !== 48'd0) begin n_fail++; $display("FAIL perf_clr got=%0h exp=0", {p0_done_cnt, p1_done_cnt, stall_cnt}); end
    @(posedge wb_clk_i);
    #1;
  endtask
`endif

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_hold();
    test_reset_mid();
`ifdef GCD_ARB_PERF_EN
    test_perf();
`endif
    n_tests++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got p0=%0d p1=%0d pending exp=0", exp0_q.size(), exp1_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish by 200000 ns exp finish");
    $fatal(1, "timeout");
  end

endmodule
